// File: rtl/axi_pkg.sv
// axi_pkg: handshake state encoding and burst types shared by the AXI read/write path FSM models.
package axi_pkg;

  typedef enum logic [1:0] {
    HS_WAIT   = 2'b00,
    HS_COMMIT = 2'b01,
    HS_ASSERT = 2'b10
  } axi_hs_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  function automatic int unsigned beat_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_rd_beat_addr.sv
// axi_rd_beat_addr: per-beat address generator for FIXED/INCR/WRAP read bursts.
// Burst shape is captured on load so a queued AR cannot disturb the burst in flight.
module axi_rd_beat_addr
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          axi_aclk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] beat_addr
);

  logic [7:0]    len_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic [AW-1:0] incr;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] addr_nxt;

  always_comb begin
    incr      = AW'(beat_bytes(size_q));
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    incr_addr = beat_addr + incr;
    addr_nxt  = beat_addr;
    case (burst_q)
      BURST_INCR: addr_nxt = incr_addr;
      BURST_WRAP: addr_nxt = (beat_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    addr_nxt = beat_addr;  // FIXED and reserved
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      beat_addr <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
    end else if (load) begin
      beat_addr <= addr;
      len_q     <= len;
      size_q    <= size;
      burst_q   <= burst;
    end else if (step) begin
      beat_addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/axi_read_protocol.sv
// axi_read_protocol: cycle-level AR/R read-path FSM model with a single outstanding burst.
// Define AXI_RD_BURST_ADDR_EN to add the axi_rbeat_addr per-beat address output.
module axi_read_protocol
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          axi_aclk,
  input  logic          rst,
  input  logic [AW-1:0] araddr_in,
  input  logic [7:0]    arlen_in,
  input  logic [2:0]    arsize_in,
  input  logic [1:0]    arburst_in,
  input  logic          arvalid_in,
  input  logic [DW-1:0] rdata_in,
  input  logic [1:0]    rresp_in,
  input  logic          rvalid_in,
  input  logic          rready_in,
  output logic [AW-1:0] axi_araddr,
  output logic [7:0]    axi_arlen,
  output logic [2:0]    axi_arsize,
  output logic [1:0]    axi_arburst,
  output logic          axi_arvalid,
  output logic          axi_arready,
  output logic [DW-1:0] axi_rdata,
  output logic [1:0]    axi_rresp,
  output logic          axi_rlast,
  output logic          axi_rvalid,
  output logic          axi_rready
`ifdef AXI_RD_BURST_ADDR_EN
  ,
  output logic [AW-1:0] axi_rbeat_addr
`endif
);

  axi_hs_state_e ar_state, ar_state_nxt;
  axi_hs_state_e r_state, r_state_nxt;
  logic          r_active, r_active_nxt;
  logic [7:0]    beats_left, beats_left_nxt;
  logic          arready_nxt, rready_nxt, rlast_nxt;
  logic          ar_latch, r_latch;
  logic          ar_commit, r_commit;

  assign ar_commit = (ar_state == HS_COMMIT);
  assign r_commit  = (r_state == HS_COMMIT);

  // State register (also holds the registered channel outputs)
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      ar_state    <= HS_WAIT;
      r_state     <= HS_WAIT;
      r_active    <= 1'b0;
      beats_left  <= '0;
      axi_arvalid <= 1'b0;
      axi_arready <= 1'b1;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arsize  <= '0;
      axi_arburst <= '0;
      axi_rvalid  <= 1'b0;
      axi_rready  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= '0;
    end else begin
      ar_state    <= ar_state_nxt;
      r_state     <= r_state_nxt;
      r_active    <= r_active_nxt;
      beats_left  <= beats_left_nxt;
      axi_arvalid <= (ar_state_nxt != HS_WAIT);
      axi_arready <= arready_nxt;
      axi_rvalid  <= (r_state_nxt != HS_WAIT);
      axi_rready  <= rready_nxt;
      axi_rlast   <= rlast_nxt;
      if (ar_latch) begin
        axi_araddr  <= araddr_in;
        axi_arlen   <= arlen_in;
        axi_arsize  <= arsize_in;
        axi_arburst <= arburst_in;
      end
      if (r_latch) begin
        axi_rdata <= rdata_in;
        axi_rresp <= rresp_in;
      end
    end
  end

  // Next-state logic
  always_comb begin
    ar_state_nxt = ar_state;
    case (ar_state)
      HS_WAIT:   if (arvalid_in) ar_state_nxt = r_active ? HS_ASSERT : HS_COMMIT;
      HS_COMMIT: ar_state_nxt = arvalid_in ? HS_ASSERT : HS_WAIT;
      HS_ASSERT: if (!r_active) ar_state_nxt = HS_COMMIT;
      default:   ar_state_nxt = HS_WAIT;
    endcase

    r_state_nxt = r_state;
    case (r_state)
      HS_WAIT:   if (r_active && rvalid_in) r_state_nxt = rready_in ? HS_COMMIT : HS_ASSERT;
      HS_ASSERT: if (rready_in) r_state_nxt = HS_COMMIT;
      HS_COMMIT: begin
        if (axi_rlast || !rvalid_in) r_state_nxt = HS_WAIT;
        else                         r_state_nxt = rready_in ? HS_COMMIT : HS_ASSERT;
      end
      default:   r_state_nxt = HS_WAIT;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    ar_latch    = 1'b0;
    arready_nxt = axi_arready;
    case (ar_state)
      HS_WAIT: begin
        ar_latch    = arvalid_in;
        arready_nxt = !r_active;
      end
      HS_COMMIT: begin
        ar_latch    = arvalid_in;
        arready_nxt = 1'b0;
      end
      HS_ASSERT: if (!r_active) arready_nxt = 1'b1;
      default: ;
    endcase

    // With no burst in flight, R ignores the slave and keeps rready low.
    r_latch    = 1'b0;
    rready_nxt = axi_rready;
    case (r_state)
      HS_WAIT: begin
        r_latch    = r_active && rvalid_in;
        rready_nxt = r_active && rready_in;
      end
      HS_ASSERT: if (rready_in) rready_nxt = 1'b1;
      HS_COMMIT: begin
        r_latch    = !axi_rlast && rvalid_in;
        rready_nxt = !axi_rlast && rready_in;
      end
      default: ;
    endcase

    r_active_nxt   = r_active;
    beats_left_nxt = beats_left;
    rlast_nxt      = axi_rlast;
    if (ar_commit) begin
      r_active_nxt   = 1'b1;
      beats_left_nxt = axi_arlen;
      rlast_nxt      = (axi_arlen == 8'd0);
    end else if (r_commit) begin
      if (axi_rlast) begin
        r_active_nxt = 1'b0;
        rlast_nxt    = 1'b0;
      end else begin
        beats_left_nxt = beats_left - 8'd1;
        rlast_nxt      = (beats_left == 8'd1);
      end
    end
  end

`ifdef AXI_RD_BURST_ADDR_EN
  axi_rd_beat_addr #(
    .AW (AW)
  ) u_beat_addr (
    .axi_aclk  (axi_aclk),
    .rst       (rst),
    .load      (ar_commit),
    .step      (r_commit && !axi_rlast),
    .addr      (axi_araddr),
    .len       (axi_arlen),
    .size      (axi_arsize),
    .burst     (axi_arburst),
    .beat_addr (axi_rbeat_addr)
  );
`endif

endmodule

// File: tb/tb_axi_read_protocol.sv
// Self-checking bench for axi_read_protocol: handshake-level model compared every cycle plus directed literals.
module tb_axi_read_protocol;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic          axi_aclk = 1'b0;
  logic          rst;
  logic [AW-1:0] araddr_in;
  logic [7:0]    arlen_in;
  logic [2:0]    arsize_in;
  logic [1:0]    arburst_in;
  logic          arvalid_in;
  logic [DW-1:0] rdata_in;
  logic [1:0]    rresp_in;
  logic          rvalid_in;
  logic          rready_in;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;
`ifdef AXI_RD_BURST_ADDR_EN
  logic [AW-1:0] axi_rbeat_addr;
`endif

  always #5 axi_aclk = ~axi_aclk;

  axi_read_protocol #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .axi_aclk    (axi_aclk),
    .rst         (rst),
    .araddr_in   (araddr_in),
    .arlen_in    (arlen_in),
    .arsize_in   (arsize_in),
    .arburst_in  (arburst_in),
    .arvalid_in  (arvalid_in),
    .rdata_in    (rdata_in),
    .rresp_in    (rresp_in),
    .rvalid_in   (rvalid_in),
    .rready_in   (rready_in),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready)
`ifdef AXI_RD_BURST_ADDR_EN
    ,
    .axi_rbeat_addr (axi_rbeat_addr)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Closed-form address of beat k of a burst
  function automatic logic [31:0] beat_addr_f(input logic [31:0] base, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input int k);
    logic [31:0] off, win;
    off = 32'(k) << size;
    win = (32'(len) + 32'd1) << size;
    case (burst)
      BURST_INCR: return base + off;
      BURST_WRAP: return (base & ~(win - 32'd1)) | ((base + off) & (win - 32'd1));
      default:    return base;
    endcase
  endfunction

  // Handshake-level model: a burst is a base/len/shape plus a count of beats already transferred
  logic          m_arvalid, m_arready;
  logic [31:0]   m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_active;
  int            m_done;
  logic [7:0]    m_len;
  logic [31:0]   m_base;
  logic [2:0]    m_size;
  logic [1:0]    m_burst;
  logic          m_rvalid, m_rready;
  logic [63:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic [31:0]   m_beat_addr;
  logic          t_ar_hs, t_r_hs, t_act, t_last, t_ar_lat;

  always @(posedge axi_aclk) begin
    if (rst) begin
      m_arvalid = 1'b0; m_arready = 1'b1; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
      m_active = 1'b0; m_done = 0; m_len = '0; m_base = '0; m_size = '0; m_burst = '0;
      m_rvalid = 1'b0; m_rready = 1'b0; m_rdata = '0; m_rresp = '0; m_beat_addr = '0;
    end else begin
      t_ar_hs  = m_arvalid && m_arready;
      t_r_hs   = m_rvalid && m_rready;
      t_act    = m_active;
      t_last   = m_active && (m_done == int'(m_len));
      t_ar_lat = arvalid_in && (t_ar_hs || !m_arvalid);
      if (t_r_hs && t_last) begin
        m_active = 1'b0; m_rvalid = 1'b0; m_rready = 1'b0;
      end else if (t_r_hs || (!m_rvalid && t_act)) begin
        if (t_r_hs) begin
          m_done++;
          m_beat_addr = beat_addr_f(m_base, m_size, m_len, m_burst, m_done);
        end
        m_rvalid = rvalid_in;
        m_rready = rready_in;
        if (rvalid_in) begin m_rdata = rdata_in; m_rresp = rresp_in; end
      end else if (m_rvalid) begin
        m_rready = rready_in;
      end else begin
        m_rready = 1'b0;
      end
      if (t_ar_hs) begin
        m_active = 1'b1; m_done = 0; m_len = m_arlen; m_base = m_araddr;
        m_size = m_arsize; m_burst = m_arburst; m_beat_addr = m_araddr;
        m_arready = 1'b0; m_arvalid = arvalid_in;
      end else if (m_arvalid) begin
        if (!t_act) m_arready = 1'b1;
      end else begin
        m_arvalid = arvalid_in; m_arready = !t_act;
      end
      if (t_ar_lat) begin
        m_araddr = araddr_in; m_arlen = arlen_in; m_arsize = arsize_in; m_arburst = arburst_in;
      end
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [31:0] addr;
    longint      t;
  } beat_t;
  beat_t beats[$];

  always @(negedge axi_aclk) begin
    beat_t b;
    if (check_en) begin
      check("arvalid", 64'(axi_arvalid), 64'(m_arvalid));
      check("arready", 64'(axi_arready), 64'(m_arready));
      check("ar_payload", {19'd0, axi_araddr, axi_arlen, axi_arsize, axi_arburst},
                          {19'd0, m_araddr, m_arlen, m_arsize, m_arburst});
      check("rvalid", 64'(axi_rvalid), 64'(m_rvalid));
      check("rready", 64'(axi_rready), 64'(m_rready));
      check("rlast", 64'(axi_rlast), 64'(m_active && (m_done == int'(m_len))));
      check("rdata", axi_rdata, m_rdata);
      check("rresp", 64'(axi_rresp), 64'(m_rresp));
      check("ar_r_overlap", 64'((axi_arvalid && axi_arready) && (axi_rvalid && axi_rready)), 64'd0);
`ifdef AXI_RD_BURST_ADDR_EN
      check("rbeat_addr", 64'(axi_rbeat_addr), 64'(m_beat_addr));
`endif
      if (axi_rvalid && axi_rready) begin
        b.data = axi_rdata;
        b.last = axi_rlast;
`ifdef AXI_RD_BURST_ADDR_EN
        b.addr = axi_rbeat_addr;
`else
        b.addr = 32'd0;
`endif
        b.t = longint'($time);
        beats.push_back(b);
      end
    end
  end

  task automatic step();
    @(posedge axi_aclk);
    #2;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] bt);
    araddr_in = a; arlen_in = l; arsize_in = s; arburst_in = bt; arvalid_in = 1'b1;
  endtask

  task automatic idle();
    arvalid_in = 1'b0; rvalid_in = 1'b0; rready_in = 1'b0;
    repeat (4) step();
    beats.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst = 1'b1; arvalid_in = 1'b0; araddr_in = '0; arlen_in = '0; arsize_in = '0; arburst_in = '0;
    rvalid_in = 1'b0; rready_in = 1'b0; rdata_in = '0; rresp_in = '0;
    step(); step();
    check_en = 1'b1;
    @(negedge axi_aclk);
    check("rst_arvalid", 64'(axi_arvalid), 64'd0);
    check("rst_arready", 64'(axi_arready), 64'd1);
    check("rst_rvalid", 64'(axi_rvalid), 64'd0);
    check("rst_rready", 64'(axi_rready), 64'd0);
    check("rst_rlast", 64'(axi_rlast), 64'd0);
    check("rst_araddr", 64'(axi_araddr), 64'd0);
    rst = 1'b0;

    // Single beat
    set_ar(32'h1000, 8'd0, 3'd2, BURST_INCR);
    rvalid_in = 1'b1; rready_in = 1'b1; rdata_in = 64'hA0; rresp_in = 2'b00;
    step(); arvalid_in = 1'b0;
    @(negedge axi_aclk);
    check("t1_arvalid", 64'(axi_arvalid), 64'd1);
    check("t1_arready", 64'(axi_arready), 64'd1);
    check("t1_araddr", 64'(axi_araddr), 64'h1000);
    step(); step();
    @(negedge axi_aclk);
    check("t1_rvalid", 64'(axi_rvalid), 64'd1);
    check("t1_rready", 64'(axi_rready), 64'd1);
    check("t1_rlast", 64'(axi_rlast), 64'd1);
    check("t1_rdata", axi_rdata, 64'hA0);
    step(); rvalid_in = 1'b0; step();
    @(negedge axi_aclk);
    check("t1_idle_arready", 64'(axi_arready), 64'd1);
    check("t1_idle_rvalid", 64'(axi_rvalid), 64'd0);
    check("t1_nbeats", 64'(beats.size()), 64'd1);
    if (beats.size() > 0) check("t1_beat_last", 64'(beats[0].last), 64'd1);
    idle();

    // INCR burst, four back-to-back beats
    set_ar(32'h1000, 8'd3, 3'd2, BURST_INCR);
    rvalid_in = 1'b1; rready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rdata_in = 64'h200 + 64'(i); rresp_in = 2'(i);
      step(); arvalid_in = 1'b0;
    end
    check("t2_nbeats", 64'(beats.size()), 64'd4);
    if (beats.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t2_last", 64'(beats[i].last), 64'(i == 3));
`ifdef AXI_RD_BURST_ADDR_EN
        check("t2_addr", 64'(beats[i].addr), 64'h1000 + 64'(4 * i));
`endif
      end
      check("t2_back_to_back", 64'(beats[3].t - beats[0].t), 64'd30);
    end
    idle();

    // Backpressure with a changing slave payload during the stall
    set_ar(32'h1100, 8'd1, 3'd3, BURST_INCR);
    rvalid_in = 1'b1; rready_in = 1'b0; rdata_in = 64'hBEEF;
    step(); arvalid_in = 1'b0;
    step(); step();
    rdata_in = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_aclk);
      check("t3_stall_rvalid", 64'(axi_rvalid), 64'd1);
      check("t3_stall_rready", 64'(axi_rready), 64'd0);
      check("t3_stall_rdata", axi_rdata, 64'hBEEF);
      if (i < 2) step();
    end
    rready_in = 1'b1;
    repeat (4) step();
    check("t3_nbeats", 64'(beats.size()), 64'd2);
    if (beats.size() == 2) begin
      check("t3_beat0", {beats[0].data[62:0], beats[0].last}, {63'hBEEF, 1'b0});
      check("t3_beat1", {beats[1].data[62:0], beats[1].last}, {63'hDEAD, 1'b1});
    end
    idle();

    // Second AR while a burst is in flight
    set_ar(32'h2000, 8'd1, 3'd3, BURST_INCR);
    step(); arvalid_in = 1'b0;
    step();
    set_ar(32'h3000, 8'd0, 3'd3, BURST_INCR);
    step(); arvalid_in = 1'b0; araddr_in = 32'hFFFF;
    @(negedge axi_aclk);
    check("t4_assert_arvalid", 64'(axi_arvalid), 64'd1);
    check("t4_assert_arready", 64'(axi_arready), 64'd0);
    check("t4_assert_araddr", 64'(axi_araddr), 64'h3000);
    rvalid_in = 1'b1; rready_in = 1'b1; rdata_in = 64'h77;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge axi_aclk); #1;
      if (axi_arvalid && axi_arready) found = 1'b1;
    end
    check("t4_ar2_commit", 64'(found), 64'd1);
    check("t4_beats_before_ar2", 64'(beats.size()), 64'd2);
    repeat (4) step();
    check("t4_nbeats", 64'(beats.size()), 64'd3);
    if (beats.size() == 3) begin
      check("t4_a_last", 64'(beats[1].last), 64'd1);
      check("t4_b_last", 64'(beats[2].last), 64'd1);
`ifdef AXI_RD_BURST_ADDR_EN
      check("t4_b_addr", 64'(beats[2].addr), 64'h3000);
`endif
    end
    idle();

    // WRAP burst
    set_ar(32'h1008, 8'd3, 3'd2, BURST_WRAP);
    rvalid_in = 1'b1; rready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rdata_in = 64'h500 + 64'(i);
      step(); arvalid_in = 1'b0;
    end
    check("t5_nbeats", 64'(beats.size()), 64'd4);
    if (beats.size() == 4) begin
      check("t5_last3", 64'(beats[3].last), 64'd1);
      check("t5_last2", 64'(beats[2].last), 64'd0);
`ifdef AXI_RD_BURST_ADDR_EN
      check("t5_addr0", 64'(beats[0].addr), 64'h1008);
      check("t5_addr1", 64'(beats[1].addr), 64'h100C);
      check("t5_addr2", 64'(beats[2].addr), 64'h1000);
      check("t5_addr3", 64'(beats[3].addr), 64'h1004);
`endif
    end
    idle();

    // Reset after two of four beats
    set_ar(32'h4000, 8'd3, 3'd2, BURST_INCR);
    rvalid_in = 1'b1; rready_in = 1'b1; rdata_in = 64'h99;
    step(); arvalid_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge axi_aclk); #1;
      if (beats.size() >= 2) found = 1'b1;
    end
    check("t6_two_beats", 64'(found), 64'd1);
    rst = 1'b1;
    @(negedge axi_aclk);
    check("t6_arvalid", 64'(axi_arvalid), 64'd0);
    check("t6_arready", 64'(axi_arready), 64'd1);
    check("t6_rvalid", 64'(axi_rvalid), 64'd0);
    check("t6_rready", 64'(axi_rready), 64'd0);
    check("t6_rlast", 64'(axi_rlast), 64'd0);
    rst = 1'b0;
    repeat (6) step();
    check("t6_no_completion", 64'(beats.size()), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
